serial_pattern_gen: RTL and testbench



---
 rtl/serial_pattern_gen.sv | 154 +++++++++++++++
 tb/tb_serial_pattern_gen.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/serial_pattern_gen.sv
// rtl/serial_pattern_gen.sv - serial bit-pattern transmitter with frame repeat and inter-frame gap
//
// Latches a PAT_W-bit pattern on an accepted start and shifts it out MSB
// first, one bit per clock, repeat_cnt times with gap idle cycles between
// frames.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-high reset
//   start       transfer request, honoured only while busy=0
//   abort       synchronous abort of an active transfer (no done pulse)
//   pattern     pattern to send, latched on accepted start
//   repeat_cnt  number of frames, latched on accepted start
//   gap         idle cycles between frames, latched on accepted start
//   dout        serial data (registered)
//   dout_valid  dout carries a pattern bit this cycle
//   frame_start high with the MSB of every frame
//   busy        transfer in progress
//   done        one-cycle pulse after the last bit of the last frame
module serial_pattern_gen #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(4'b1010),
  parameter int               CNT_W   = 8,
  parameter int               GAP_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap,
  output logic             dout,
  output logic             dout_valid,
  output logic             frame_start,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] MSB_IDX = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state;
  logic [PAT_W-1:0] pat_q;
  logic [CNT_W-1:0] frames_left;  // includes the frame currently being sent
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_cnt;      // gap cycles remaining, including the current one
  logic [IDX_W-1:0] bit_idx;      // index of the bit currently on dout
  logic [IDX_W-1:0] idx_dn;

  assign idx_dn = bit_idx - 1'b1;

  // Outputs are computed at each edge for the cycle that follows, so the
  // state names describe what is on dout during the current cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pat_q       <= DEF_PAT;
      frames_left <= '0;
      gap_q       <= '0;
      gap_cnt     <= '0;
      bit_idx     <= '0;
      dout        <= 1'b0;
      dout_valid  <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            pat_q       <= pattern;
            frames_left <= repeat_cnt;
            gap_q       <= gap;
            if (repeat_cnt != '0) begin
              state       <= SHIFT;
              bit_idx     <= MSB_IDX;
              dout        <= pattern[PAT_W-1];
              dout_valid  <= 1'b1;
              frame_start <= 1'b1;
              busy        <= 1'b1;
            end else begin
              // Empty transfer: acknowledge immediately without going busy.
              done <= 1'b1;
            end
          end
        end

        SHIFT: begin
          if (abort) begin
            state      <= IDLE;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
          end else if (bit_idx != '0) begin
            bit_idx <= idx_dn;
            dout    <= pat_q[idx_dn];
          end else if (frames_left == CNT_W'(1)) begin
            state      <= IDLE;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
          end else begin
            frames_left <= frames_left - 1'b1;
            if (gap_q == '0) begin
              bit_idx     <= MSB_IDX;
              dout        <= pat_q[PAT_W-1];
              frame_start <= 1'b1;
            end else begin
              state      <= GAP;
              gap_cnt    <= gap_q;
              dout       <= 1'b0;
              dout_valid <= 1'b0;
            end
          end
        end

        GAP: begin
          if (abort) begin
            state      <= IDLE;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
          end else if (gap_cnt == GAP_W'(1)) begin
            state       <= SHIFT;
            bit_idx     <= MSB_IDX;
            dout        <= pat_q[PAT_W-1];
            dout_valid  <= 1'b1;
            frame_start <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end

        default: begin
          state      <= IDLE;
          dout       <= 1'b0;
          dout_valid <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_pattern_gen.sv
// tb/tb_serial_pattern_gen.sv - randomized self-checking bench for serial_pattern_gen
module tb_serial_pattern_gen;

  localparam int PAT_W = 4;
  localparam int CNT_W = 8;
  localparam int GAP_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             abort;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] repeat_cnt;
  logic [GAP_W-1:0] gap;
  logic             dout;
  logic             dout_valid;
  logic             frame_start;
  logic             busy;
  logic             done;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  serial_pattern_gen #(
    .PAT_W  (PAT_W),
    .DEF_PAT(4'b1010),
    .CNT_W  (CNT_W),
    .GAP_W  (GAP_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .pattern    (pattern),
    .repeat_cnt (repeat_cnt),
    .gap        (gap),
    .dout       (dout),
    .dout_valid (dout_valid),
    .frame_start(frame_start),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Expected output word per cycle: {dout, dout_valid, frame_start, busy, done}
  logic [4:0] exp_q[$];
  logic [4:0] cur_exp = 5'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %b want %b", tag, cyc, got[4:0], want[4:0]);
    end
  endtask

  // Whole transfer expanded into a per-cycle list straight from the rules:
  // frames of MSB-first bits, gap idle cycles between frames, then a done cycle.
  task automatic model_edge();
    if (reset) begin
      exp_q.delete();
      cur_exp = 5'b0;
    end else if (!cur_exp[1] && start) begin
      exp_q.delete();
      for (int f = 0; f < int'(repeat_cnt); f++) begin
        for (int b = PAT_W - 1; b >= 0; b--)
          exp_q.push_back({pattern[b], 1'b1, (b == PAT_W - 1), 1'b1, 1'b0});
        if (f < int'(repeat_cnt) - 1)
          for (int g = 0; g < int'(gap); g++)
            exp_q.push_back(5'b00010);
      end
      exp_q.push_back(5'b00001);
      cur_exp = exp_q.pop_front();
    end else if (cur_exp[1] && abort) begin
      exp_q.delete();
      cur_exp = 5'b0;
    end else if (exp_q.size() != 0) begin
      cur_exp = exp_q.pop_front();
    end else begin
      cur_exp = 5'b0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
    check_eq("outs", {27'b0, dout, dout_valid, frame_start, busy, done}, {27'b0, cur_exp});
  endtask

  task automatic idle_inputs();
    start = 1'b0;
    abort = 1'b0;
    reset = 1'b0;
  endtask

  task automatic pulse_start(input logic [PAT_W-1:0] p, input int rc, input int g);
    pattern    = p;
    repeat_cnt = CNT_W'(rc);
    gap        = GAP_W'(g);
    start      = 1'b1;
    cycle();
    start      = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    pattern = '0; repeat_cnt = '0; gap = '0;
    run(2);
    idle_inputs();
    run(2);

    // single frame, back-to-back frames, gapped frames, zero count
    pulse_start(4'b1010, 1, 0); run(6);
    pulse_start(4'b1010, 3, 0); run(14);
    pulse_start(4'b1100, 2, 2); run(12);
    pulse_start(4'b1010, 0, 0); run(3);

    // config change plus start while busy must be ignored
    pulse_start(4'b1010, 2, 1); run(2);
    pattern = 4'b0110; repeat_cnt = 8'd5; gap = 4'd0;
    start = 1'b1; run(2); start = 1'b0; run(10);

    // abort mid-frame, then a fresh transfer
    pulse_start(4'b1011, 2, 0); run(1);
    abort = 1'b1; cycle(); abort = 1'b0; run(2);
    pulse_start(4'b1001, 2, 0); run(10);

    // abort during a gap; abort and start together while idle
    pulse_start(4'b1111, 3, 3); run(5);
    abort = 1'b1; cycle(); abort = 1'b0; run(1);
    abort = 1'b1; pulse_start(4'b0101, 1, 0); abort = 1'b0; run(6);

    // reset mid-frame
    pulse_start(4'b1110, 2, 0); run(2);
    reset = 1'b1; start = 1'b1; cycle(); reset = 1'b0; start = 1'b0; run(3);

    // restart in the done cycle, bounded wait for the done pulse
    pulse_start(4'b1101, 1, 0);
    for (int i = 0; i < 20 && !cur_exp[0]; i++) cycle();
    check_eq("done_reached", {31'b0, done}, 32'd1);
    pulse_start(4'b0011, 2, 1); run(12);

    // maximum frame count
    pulse_start(4'b1001, 255, 0); run(1025);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      start      = ($urandom_range(0, 5) == 0);
      abort      = ($urandom_range(0, 24) == 0);
      reset      = ($urandom_range(0, 299) == 0);
      pattern    = PAT_W'($urandom);
      repeat_cnt = CNT_W'($urandom_range(0, 4));
      gap        = GAP_W'($urandom_range(0, 3));
      cycle();
    end
    idle_inputs();
    run(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
